iter_mult: RTL and testbench
============================

Name: iter_mult

Overview:
Parametrised iterative shift-and-add multiplier. The datapath and the control FSM are merged into one block. It generalises the team's fixed repeated-addition multiplier control path with:
- configurable operand width
- signed/unsigned mode selected per operation
- valid/ready handshakes on both input and output
- optional early termination
- synchronous abort

It sits between the operand-issue logic and the result sink in the arithmetic unit.

Parameters:
WIDTH, 8, operand width in bits (>=2); product is 2*WIDTH bits.
EARLY_EXIT, 1, when 1 the iteration stops as soon as the remaining multiplier bits are all zero; when 0 it always runs WIDTH iterations.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  operands a, b, is_signed are valid.
in_ready  output  1  block can accept operands; 1 only in IDLE.
a  input  WIDTH  multiplicand.
b  input  WIDTH  multiplier.
is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
abort  input  1  synchronous cancel of the operation in progress.
busy  output  1  1 in RUN.
out_valid  output  1  product is valid; 1 only in DONE.
out_ready  input  1  sink accepts product.
product  output  2*WIDTH  result, two's-complement when is_signed was 1.
cycles  output  $clog2(WIDTH+1)  number of RUN cycles used by the last completed operation.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - acc, mcand, mplier, count, product, cycles, neg all 0.
  - out_valid=0, busy=0.
  - in_ready=1 once in IDLE; in_ready is decoded from state, so it also reads 1 while rst is held.
- States: IDLE, RUN, DONE. Outputs are decoded from the state register (Moore).
- IDLE:
  - in_ready=1.
  - On the edge where in_valid=1, register:
    - mcand = |a| zero-extended to 2*WIDTH.
    - mplier = |b| (WIDTH bits).
    - neg = is_signed & (a[MSB]^b[MSB]).
    - acc = 0, count = 0.
    - Go to RUN.
  - Magnitude rules: |x| = -x when is_signed & x[MSB], else x. The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which fits unsigned in WIDTH bits.
- RUN, each cycle:
  - If mplier[0]=1: acc += mcand (2*WIDTH bits, no overflow possible).
  - mcand <<= 1; mplier >>= 1; count += 1.
  - Exit to DONE when the updated count == WIDTH, or when EARLY_EXIT=1 and the updated mplier == 0.
  - On the exiting edge:
    - product = neg ? -(acc_next) : acc_next, where acc_next includes the add made in that same cycle.
    - cycles = count_next.
- RUN length:
  - EARLY_EXIT=0: always WIDTH.
  - EARLY_EXIT=1: max(1, position of the highest set bit of |b| + 1). For |b|=0 this is 1 cycle.
- DONE:
  - out_valid=1; product and cycles are held stable.
  - On an edge with out_ready=1, go to IDLE.
  - in_valid is ignored while in RUN and DONE; there is no back-to-back accept from DONE.
- Accept-to-out_valid latency: RUN length + 1 edges. The earliest re-accept is 1 cycle after the out_ready handshake.
- abort:
  - In RUN or DONE, abort=1 forces IDLE on the next edge. No result is delivered.
  - product and cycles keep their previous values.
  - abort has priority over the RUN exit and over out_ready.
  - In IDLE, abort is ignored, and an in_valid on the same edge is still accepted.
- Reset mid-operation: returns immediately to IDLE with all registers cleared. No partial result is visible.
- Operands are only sampled on the accept edge; later changes on a, b, is_signed have no effect.
- product and cycles change only on a RUN->DONE transition or on reset.

Test Plan:
- WIDTH=8, EARLY_EXIT=1, unsigned 13*5 -> product=65 (0x0041), cycles=3, out_valid 4 edges after accept.
- Unsigned 255*255 -> product=65025 (0xFE01), cycles=8. Repeat with EARLY_EXIT=0 and 13*5 -> product=65, cycles=8.
- Signed checks:
  - a=0xFD (-3), b=7 -> product=0xFFEB (-21), cycles=3.
  - a=0x80, b=0x80 (-128*-128) -> product=0x4000 (16384), cycles=8.
  - a=0x80, b=1 -> product=0xFF80, cycles=1.
- b=0 with a=0xFF, unsigned -> product=0, cycles=1. Then check backpressure:
  - Hold out_ready=0 for 5 cycles: out_valid stays 1, product stable, in_ready=0.
  - A pulsed in_valid during this time is ignored.
  - out_ready=1 -> IDLE next edge.
- Abort in RUN cycle 2 of 200*200 (unsigned):
  - IDLE next edge; out_valid never asserts; product/cycles keep the previous result.
  - A new accept of 3*4 yields 12.
- Assert rst asynchronously mid-RUN: state=IDLE, product=0, cycles=0, out_valid=0, busy=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/iter_mult.sv
// Iterative shift-and-add multiplier with signed/unsigned mode, optional early exit,
// valid/ready handshakes on both sides and a synchronous abort.
module iter_mult #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  input  logic                         is_signed,
  input  logic                         abort,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2*WIDTH-1:0]           product,
  output logic [$clog2(WIDTH+1)-1:0]   cycles
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0]      WIDTH_C = CW'(WIDTH);
  localparam logic [CW-1:0]      ONE_C   = CW'(1);
  localparam logic [WIDTH-1:0]   ONE_W   = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W  = (2*WIDTH)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [2*WIDTH-1:0]   acc_r, acc_s, mcand_r, mcand_s, res_s;
  logic [WIDTH-1:0]     mplier_r, mplier_s;
  logic [CW-1:0]        count_r, count_s;
  logic                 neg_r, exit_s;

  // Magnitude of a two's-complement operand; -2^(WIDTH-1) maps onto itself as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    if (sgn && x[WIDTH-1]) begin
      mag = ~x + ONE_W;
    end else begin
      mag = x;
    end
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // One iteration of the datapath and the exit test on its updated values.
  always_comb begin
    acc_s = acc_r;
    if (mplier_r[0]) begin
      acc_s = acc_r + mcand_r;
    end else begin
      acc_s = acc_r;
    end
    mcand_s  = {mcand_r[2*WIDTH-2:0], 1'b0};
    mplier_s = {1'b0, mplier_r[WIDTH-1:1]};
    count_s  = count_r + ONE_C;
    exit_s   = (count_s == WIDTH_C) || ((EARLY_EXIT != 0) && (mplier_s == '0));
    if (neg_r) begin
      res_s = ~acc_s + ONE_2W;
    end else begin
      res_s = acc_s;
    end
  end

  // Next-state logic; abort outranks both the RUN exit and the output handshake.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_s = IDLE;
        end else if (exit_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (abort || out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Datapath registers: operand capture on accept, iteration in RUN, result on exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      count_r  <= '0;
      neg_r    <= 1'b0;
      product  <= '0;
      cycles   <= '0;
    end else if ((state_r == IDLE) && in_valid) begin
      acc_r    <= '0;
      mcand_r  <= {{WIDTH{1'b0}}, mag(a, is_signed)};
      mplier_r <= mag(b, is_signed);
      count_r  <= '0;
      neg_r    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if ((state_r == RUN) && !abort) begin
      acc_r    <= acc_s;
      mcand_r  <= mcand_s;
      mplier_r <= mplier_s;
      count_r  <= count_s;
      if (exit_s) begin
        product <= res_s;
        cycles  <= count_s;
      end
    end
  end

endmodule

// File: tb/tb_iter_mult.sv
// Bench for iter_mult: an early-exit and a full-length instance share operands and are
// checked every cycle against a transaction-level model plus hand-computed results.
module tb_iter_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid1 = 1'b0, in_valid0 = 1'b0;
  logic [7:0]  a = 8'd0, b = 8'd0;
  logic        is_signed = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic        in_ready1, busy1, out_valid1, in_ready0, busy0, out_valid0;
  logic [15:0] product1, product0;
  logic [3:0]  cycles1, cycles0;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  iter_mult #(.WIDTH(8), .EARLY_EXIT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a), .b(b), .is_signed(is_signed), .abort(abort), .busy(busy1),
    .out_valid(out_valid1), .out_ready(out_ready), .product(product1), .cycles(cycles1)
  );

  iter_mult #(.WIDTH(8), .EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a), .b(b), .is_signed(is_signed), .abort(abort), .busy(busy0),
    .out_valid(out_valid0), .out_ready(out_ready), .product(product0), .cycles(cycles0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the operand values.
  function automatic logic [15:0] ref_prod(input logic [7:0] x, input logic [7:0] y, input logic s);
    int ix, iy, p;
    ix = s ? int'($signed(x)) : int'(x);
    iy = s ? int'($signed(y)) : int'(y);
    p  = ix * iy;
    return p[15:0];
  endfunction

  function automatic logic [3:0] ref_cyc(input logic [7:0] y, input logic s, input bit ee);
    int iy, m, n;
    if (!ee) return 4'd8;
    iy = s ? int'($signed(y)) : int'(y);
    m  = (iy < 0) ? -iy : iy;
    n  = 1;
    for (int i = 0; i < 8; i++) if (m[i]) n = i + 1;
    return n[3:0];
  endfunction

  // Model: phase 0 idle, 1 computing (left = edges remaining), 2 holding a result.
  int          ph[2], left[2];
  logic [15:0] mp[2], pp[2];
  logic [3:0]  mc[2], pc[2];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        ph[k] = 0; mp[k] = 16'd0; mc[k] = 4'd0; left[k] = 0;
      end else if (ph[k] == 0) begin
        if ((k == 1) ? in_valid1 : in_valid0) begin
          ph[k]   = 1;
          pp[k]   = ref_prod(a, b, is_signed);
          pc[k]   = ref_cyc(b, is_signed, k == 1);
          left[k] = int'(pc[k]);
        end
      end else if (ph[k] == 1) begin
        if (abort) ph[k] = 0;
        else begin
          left[k]--;
          if (left[k] == 0) begin
            ph[k] = 2; mp[k] = pp[k]; mc[k] = pc[k];
          end
        end
      end else if (abort || out_ready) begin
        ph[k] = 0;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("in_ready1",  {31'd0, in_ready1},  {31'd0, ph[1] == 0});
    chk("busy1",      {31'd0, busy1},      {31'd0, ph[1] == 1});
    chk("out_valid1", {31'd0, out_valid1}, {31'd0, ph[1] == 2});
    chk("product1",   {16'd0, product1},   {16'd0, mp[1]});
    chk("cycles1",    {28'd0, cycles1},    {28'd0, mc[1]});
    chk("in_ready0",  {31'd0, in_ready0},  {31'd0, ph[0] == 0});
    chk("busy0",      {31'd0, busy0},      {31'd0, ph[0] == 1});
    chk("out_valid0", {31'd0, out_valid0}, {31'd0, ph[0] == 2});
    chk("product0",   {16'd0, product0},   {16'd0, mp[0]});
    chk("cycles0",    {28'd0, cycles0},    {28'd0, mc[0]});
  end

  // Issue one operation, scramble operands after accept, wait for the result and pin it.
  task automatic run_op(input bit sel, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic s, input logic [15:0] ep, input logic [3:0] ec,
                        input bit release_now);
    int n;
    @(negedge clk);
    a = ta; b = tb_; is_signed = s;
    if (sel) in_valid1 = 1'b1; else in_valid0 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0; in_valid0 = 1'b0;
    a = 8'h5A; b = 8'hC3; is_signed = ~s;
    n = 1;
    while (!(sel ? out_valid1 : out_valid0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 32'(ec) + 32'd1);
    chk("lit_product", {16'd0, sel ? product1 : product0}, {16'd0, ep});
    chk("lit_cycles", {28'd0, sel ? cycles1 : cycles0}, {28'd0, ec});
    if (release_now) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  initial begin
    #12;
    chk("reset_in_ready", {31'd0, in_ready1}, 32'd1);
    chk("reset_product", {16'd0, product1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(1'b1, 8'd13,  8'd5,   1'b0, 16'h0041, 4'd3, 1'b1);
    run_op(1'b1, 8'd255, 8'd255, 1'b0, 16'hFE01, 4'd8, 1'b1);
    run_op(1'b0, 8'd13,  8'd5,   1'b0, 16'h0041, 4'd8, 1'b1);
    run_op(1'b1, 8'hFD,  8'd7,   1'b1, 16'hFFEB, 4'd3, 1'b1);
    run_op(1'b0, 8'hFD,  8'd7,   1'b1, 16'hFFEB, 4'd8, 1'b1);
    run_op(1'b1, 8'h80,  8'h80,  1'b1, 16'h4000, 4'd8, 1'b1);
    run_op(1'b1, 8'h80,  8'd1,   1'b1, 16'hFF80, 4'd1, 1'b1);

    // Backpressure: result held, in_valid ignored while DONE.
    run_op(1'b1, 8'hFF,  8'd0,   1'b0, 16'h0000, 4'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid1 = (i == 2);
      a = 8'd9; b = 8'd9;
    end
    @(negedge clk);
    in_valid1 = 1'b0;
    chk("bp_out_valid", {31'd0, out_valid1}, 32'd1);
    chk("bp_in_ready", {31'd0, in_ready1}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_released", {31'd0, in_ready1}, 32'd1);

    // Abort on the second RUN edge of 200*200.
    a = 8'd200; b = 8'd200; is_signed = 1'b0; in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", {31'd0, in_ready1}, 32'd1);
    chk("abort_product", {16'd0, product1}, 32'd0);
    chk("abort_cycles", {28'd0, cycles1}, 32'd1);
    repeat (10) @(negedge clk);
    run_op(1'b1, 8'd3, 8'd4, 1'b0, 16'd12, 4'd3, 1'b1);

    // Asynchronous reset in the middle of RUN.
    a = 8'd255; b = 8'd255; in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", {31'd0, in_ready1}, 32'd1);
    chk("arst_busy", {31'd0, busy1}, 32'd0);
    chk("arst_out_valid", {31'd0, out_valid1}, 32'd0);
    chk("arst_product", {16'd0, product1}, 32'd0);
    chk("arst_cycles", {28'd0, cycles1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
